// File: rtl/d_branch_cmp.sv
// ============================================================================
// d_branch_cmp -- branch condition evaluator with operand-wait FSM and stats.
// Rev 1.0
// ============================================================================
`default_nettype none

module d_branch_cmp #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             a_rdy,
  input  logic             b_rdy,
  input  logic             flush,
  output logic             stall,
  output logic             res_valid,
  output logic             taken,
  output logic             equal,
  output logic             op_err,
  output logic [CNT_W-1:0] cnt_total,
  output logic [CNT_W-1:0] cnt_taken
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             res_valid_q, res_valid_d;
  logic             taken_q, taken_d;
  logic             equal_q, equal_d;
  logic             op_err_q, op_err_d;
  logic [CNT_W-1:0] cnt_total_q, cnt_total_d;
  logic [CNT_W-1:0] cnt_taken_q, cnt_taken_d;

  logic [2:0]       w_eff_op;
  logic             w_legal;
  logic             w_ops_ready;
  logic             w_cond;
  logic             w_eval;
  logic             w_a_neg;
  logic             w_a_zero;

  always_comb begin
    // A new request is evaluated with its live op; a waiting one uses the latched op.
    w_eff_op    = (state_q == IDLE) ? op : op_q;
    w_legal     = (w_eff_op <= 3'd5);
    w_ops_ready = !w_legal || (a_rdy && ((w_eff_op >= 3'd2) || b_rdy));
    w_a_neg     = a[WIDTH-1];
    w_a_zero    = (a == '0);

    case (w_eff_op)
      3'd0:    w_cond = (a == b);
      3'd1:    w_cond = (a != b);
      3'd2:    w_cond = w_a_neg || w_a_zero;
      3'd3:    w_cond = !w_a_neg && !w_a_zero;
      3'd4:    w_cond = w_a_neg;
      3'd5:    w_cond = !w_a_neg;
      default: w_cond = 1'b0;
    endcase

    state_d     = state_q;
    op_d        = op_q;
    w_eval      = 1'b0;

    if (flush) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (req_valid) begin
        op_d = op;
        if (w_ops_ready) w_eval = 1'b1;
        else             state_d = WAIT;
      end
    end else if (w_ops_ready) begin
      w_eval  = 1'b1;
      state_d = IDLE;
    end

    res_valid_d = w_eval;
    taken_d     = taken_q;
    equal_d     = equal_q;
    op_err_d    = op_err_q;
    cnt_total_d = cnt_total_q;
    cnt_taken_d = cnt_taken_q;

    if (w_eval) begin
      taken_d  = w_cond;
      equal_d  = (a == b);
      op_err_d = !w_legal;
      if (cnt_total_q != '1) cnt_total_d = cnt_total_q + CNT_ONE;
      if (w_cond && (cnt_taken_q != '1)) cnt_taken_d = cnt_taken_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_q        <= 3'd0;
      res_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      equal_q     <= 1'b0;
      op_err_q    <= 1'b0;
      cnt_total_q <= '0;
      cnt_taken_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      res_valid_q <= res_valid_d;
      taken_q     <= taken_d;
      equal_q     <= equal_d;
      op_err_q    <= op_err_d;
      cnt_total_q <= cnt_total_d;
      cnt_taken_q <= cnt_taken_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign stall     = (state_q == WAIT);
  assign res_valid = res_valid_q;
  assign taken     = taken_q;
  assign equal     = equal_q;
  assign op_err    = op_err_q;
  assign cnt_total = cnt_total_q;
  assign cnt_taken = cnt_taken_q;

endmodule

`default_nettype wire
